// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// led_pwm_driver: Avalon-MM controlled 8-channel LED PWM with blink and invert.
// Revision: 1.0
// ============================================================================
module led_pwm_driver #(
  parameter int PRESCALE = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pattern_in,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] led_out
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  localparam logic [1:0] ADDR_BRIGHT = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [7:0]  bright;
  logic [2:0]  ctrl;
  logic [7:0]  period;

  logic [15:0] prescaler;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_sh;
  logic [7:0]  pat_sh;
  logic [7:0]  blink_cnt;
  logic        blink_phase;

  logic        en;
  logic        blink;
  logic        inv;
  logic        wr_en;
  logic        step;
  logic        frame_end;
  logic        pwm_on;
  logic        blink_active;
  logic [8:0]  blink_next;
  logic        blink_wrap;
  logic [7:0]  raw;

  assign en    = ctrl[0];
  assign blink = ctrl[1];
  assign inv   = ctrl[2];
  assign wr_en = chipselect & ~write_n;

  assign step      = en & (prescaler == PRESCALE_LAST);
  assign frame_end = step & (pwm_cnt == 8'hFF);

  // Full scale must be steady on, which the plain compare cannot express.
  assign pwm_on = (duty_sh == 8'hFF) | (pwm_cnt < duty_sh);

  assign blink_active = blink & (period != 8'd0);
  assign blink_next   = {1'b0, blink_cnt} + 9'd1;
  // >= rather than == so a PERIOD lowered below the running count still wraps.
  assign blink_wrap   = blink_next >= {1'b0, period};

  assign raw = pat_sh & {8{en & pwm_on & blink_phase}};

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bright <= 8'hFF;
      ctrl   <= 3'b001;
      period <= 8'h00;
    end else if (wr_en) begin
      case (address)
        ADDR_BRIGHT: bright <= writedata;
        ADDR_CTRL:   ctrl   <= writedata[2:0];
        ADDR_PERIOD: period <= writedata;
        default:     ;
      endcase
    end
  end

  // Prescaler and PWM position; both parked at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= 16'd0;
      pwm_cnt   <= 8'd0;
    end else if (!en) begin
      prescaler <= 16'd0;
      pwm_cnt   <= 8'd0;
    end else if (step) begin
      prescaler <= 16'd0;
      pwm_cnt   <= pwm_cnt + 8'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // Frame-boundary shadows keep a frame glitch-free under mid-frame updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_sh <= 8'hFF;
      pat_sh  <= 8'h00;
    end else if (!en || frame_end) begin
      duty_sh <= bright;
      pat_sh  <= pattern_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else if (!en || !blink_active) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_wrap) begin
        blink_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_next[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= 8'h00;
    end else begin
      led_out <= inv ? ~raw : raw;
    end
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      ADDR_BRIGHT: readdata = bright;
      ADDR_CTRL:   readdata = {5'b0, ctrl};
      ADDR_PERIOD: readdata = period;
      ADDR_STATUS: readdata = {5'b0, blink_phase, pwm_on, en};
      default:     readdata = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// Randomized and scenario-driven bench for led_pwm_driver against a frame-level model.
module tb_led_pwm_driver;

  localparam int P     = 1;
  localparam int FRAME = 256 * P;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] pattern_in = 8'h00;
  logic [1:0] address    = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n    = 1'b1;
  logic [7:0] writedata  = 8'h00;
  logic [7:0] readdata;
  logic [7:0] led_out;

  led_pwm_driver #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: registers, time since enable, latched frame values, blink.
  logic [7:0] m_bright, m_period, m_duty, m_pat, m_led;
  logic [2:0] m_ctrl;
  int         m_tick;
  int         m_frames;
  bit         m_phase;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_on();
    int pos;
    pos = (m_tick / P) % 256;
    return (m_duty == 8'hFF) || (pos < int'(m_duty));
  endfunction

  function automatic logic [7:0] exp_rd();
    case (address)
      2'd0:    return m_bright;
      2'd1:    return {5'b0, m_ctrl};
      2'd2:    return m_period;
      default: return {5'b0, m_phase, m_on(), m_ctrl[0]};
    endcase
  endfunction

  task automatic model_reset();
    m_bright = 8'hFF; m_ctrl = 3'b001; m_period = 8'h00;
    m_duty = 8'hFF; m_pat = 8'h00; m_led = 8'h00;
    m_tick = 0; m_frames = 0; m_phase = 1'b1;
  endtask

  task automatic model_step();
    bit         en;
    bit         fe;
    logic [7:0] raw;
    en  = m_ctrl[0];
    raw = (en && m_on() && m_phase) ? m_pat : 8'h00;
    fe  = en && ((m_tick % FRAME) == FRAME - 1);
    if (!en) begin
      m_tick = 0; m_duty = m_bright; m_pat = pattern_in;
    end else begin
      m_tick++;
      if (fe) begin m_duty = m_bright; m_pat = pattern_in; end
    end
    if (!en || !m_ctrl[1] || m_period == 8'd0) begin
      m_frames = 0; m_phase = 1'b1;
    end else if (fe) begin
      if (m_frames + 1 >= int'(m_period)) begin
        m_phase = !m_phase; m_frames = 0;
      end else begin
        m_frames++;
      end
    end
    m_led = m_ctrl[2] ? ~raw : raw;
    if (chipselect && !write_n) begin
      case (address)
        2'd0:    m_bright = writedata;
        2'd1:    m_ctrl   = writedata[2:0];
        2'd2:    m_period = writedata;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check("led_out", led_out, m_led);
    check("readdata", readdata, exp_rd());
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_led", led_out, 8'h00);
    check("rst_rd", readdata, exp_rd());
    run(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] a;
    int         r;

    model_reset();
    run(3);
    reset_n    = 1'b1;
    pattern_in = 8'hA5;
    run(600);
    address = 2'd0; run(1);
    address = 2'd1; run(1);
    address = 2'd2; run(1);

    wr(2'd0, 8'h40);
    pattern_in = 8'hFF;
    address    = 2'd3;
    run(600);

    wr(2'd0, 8'h00);
    run(300);
    wr(2'd1, 8'h05);
    run(300);

    wr(2'd0, 8'hFF);
    wr(2'd2, 8'h02);
    wr(2'd1, 8'h03);
    address = 2'd3;
    run(2200);

    run(100);
    pattern_in = 8'h3C;
    run(400);

    wr(2'd1, 8'h00);
    run(50);
    wr(2'd1, 8'h01);
    address = 2'd3;
    run(300);
    wr(2'd3, 8'hFF);
    address = 2'd3;
    run(10);

    wr(2'd1, 8'h03);
    wr(2'd2, 8'h05);
    run(FRAME * 3 + 50);
    wr(2'd2, 8'h01);
    address = 2'd3;
    run(600);

    run(77);
    do_reset();
    run(300);

    repeat (8000) begin
      r = $urandom_range(0, 999);
      if (r == 0) begin
        do_reset();
      end else if (r < 30) begin
        a = 2'($urandom_range(0, 3));
        d = 8'($urandom);
        if (a == 2'd2) d = 8'($urandom_range(0, 3));
        if (a == 2'd1) begin
          d = 8'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        wr(a, d);
      end else begin
        if (r < 60) pattern_in = 8'($urandom);
        address = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
